ysyx_22040759_dmem_resp: RTL and testbench

- Responder end of the MEM-stage data-memory handshake (mem_valid/mem_req/mem_addr/mem_size/mem_data_write, answered by mem_ready/mem_data_read).
- Accepts one load or store at a time from the MEM stage and converts it to a 64-bit-wide SRAM-style request/grant/rvalid interface with byte strobes.
- Aligns and sign/zero-extends load data per func3, then returns a single-cycle mem_ready pulse.
- Sits between the MEM stage and the data SRAM/bus adapter.

---
 rtl/ysyx_22040759_dmem_resp.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22040759_dmem_resp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_dmem_resp.sv
// MEM-stage data-memory responder: turns one load/store at a time into a 64-bit
// SRAM request/grant/rvalid transaction and returns an aligned, extended result.
module ysyx_22040759_dmem_resp #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_size,
  input  logic [63:0]       mem_data_write,
  output logic              mem_ready,
  output logic [63:0]       mem_data_read,
  output logic              mem_misalign,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  output logic [7:0]        ram_wstrb,
  input  logic              ram_gnt,
  input  logic              ram_rvalid,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              misalign_in;
  logic [63:0]       rd_sh;
  logic [63:0]       load_data;
  logic [7:0]        byte_mask;

  // Natural alignment depends only on the access width, so loads and stores share it.
  always_comb begin
    misalign_in = 1'b0;
    case (mem_size[1:0])
      2'd1:    misalign_in = mem_addr[0];
      2'd2:    misalign_in = |mem_addr[1:0];
      2'd3:    misalign_in = |mem_addr[2:0];
      default: misalign_in = 1'b0;
    endcase
  end

  always_comb begin
    rd_sh     = ram_rdata >> {addr_q[2:0], 3'b000};
    load_data = '0;
    case (size_q)
      3'd0:    load_data = {{56{rd_sh[7]}},  rd_sh[7:0]};
      3'd1:    load_data = {{48{rd_sh[15]}}, rd_sh[15:0]};
      3'd2:    load_data = {{32{rd_sh[31]}}, rd_sh[31:0]};
      3'd3:    load_data = rd_sh;
      3'd4:    load_data = {56'd0, rd_sh[7:0]};
      3'd5:    load_data = {48'd0, rd_sh[15:0]};
      3'd6:    load_data = {32'd0, rd_sh[31:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_mask = 8'h01;
    case (size_q[1:0])
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          size_d  = mem_size;
          wdata_d = mem_data_write;
          we_d    = mem_req;
          mis_d   = misalign_in;
          if (misalign_in) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      // rvalid coinciding with the grant is deliberately not looked at here
      S_REQ: begin
        if (ram_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ram_rvalid) begin
          rdata_d = we_q ? '0 : load_data;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_DRAIN;
      // Hold off until the MEM stage withdraws, so one request is served once.
      S_DRAIN: begin
        if (!mem_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready     = 1'b0;
    mem_misalign  = 1'b0;
    mem_data_read = rdata_q;
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    ram_wstrb     = '0;
    case (state_q)
      S_REQ: begin
        ram_req   = 1'b1;
        ram_we    = we_q;
        ram_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        ram_wdata = we_q ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
        ram_wstrb = we_q ? (byte_mask << addr_q[2:0]) : '0;
      end
      S_RESP: begin
        mem_ready    = 1'b1;
        mem_misalign = mis_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040759_dmem_resp.sv
// Directed bench for ysyx_22040759_dmem_resp: loads, stores, misalignment,
// stalled grant with a lingering mem_valid, and reset in the middle of a transaction.
module tb_ysyx_22040759_dmem_resp;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [63:0] mem_data_write;
  logic        mem_ready;
  logic [63:0] mem_data_read;
  logic        mem_misalign;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_gnt;
  logic        ram_rvalid;
  logic [63:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  int          o_rdy, o_reqs, o_rdycyc;
  logic [63:0] o_data, o_wdata;
  logic        o_mis, o_we;
  logic [7:0]  o_strb;
  logic [31:0] o_raddr;

  ysyx_22040759_dmem_resp #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_size       (mem_size),
    .mem_data_write (mem_data_write),
    .mem_ready      (mem_ready),
    .mem_data_read  (mem_data_read),
    .mem_misalign   (mem_misalign),
    .ram_req        (ram_req),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_wstrb      (ram_wstrb),
    .ram_gnt        (ram_gnt),
    .ram_rvalid     (ram_rvalid),
    .ram_rdata      (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle mem_valid is first presented. The RAM model grants after
  // gdly request cycles and returns rvalid two cycles after the grant cycle.
  task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] sz,
                      input logic [63:0] wd, input logic [63:0] rd,
                      input int gdly, input int hold, input logic early);
    int   reqcnt;
    int   gcyc;
    int   rdy_seen;
    logic prev_req;
    reqcnt = 0; gcyc = -1; rdy_seen = -1; prev_req = 1'b0;
    o_rdy = 0; o_reqs = 0; o_rdycyc = -1; o_data = '1; o_mis = 1'b0;
    o_we = 1'b0; o_strb = '0; o_raddr = '0; o_wdata = '0;
    mem_valid = 1'b1; mem_req = we; mem_addr = a; mem_size = sz;
    mem_data_write = wd; ram_rdata = rd;
    for (int c = 1; c <= 30; c++) begin
      tick();
      ram_gnt = 1'b0;
      ram_rvalid = 1'b0;
      if (early) mem_valid = 1'b0;
      if (ram_req && !prev_req) o_reqs++;
      prev_req = ram_req;
      if (ram_req) begin
        o_raddr = ram_addr; o_strb = ram_wstrb; o_wdata = ram_wdata; o_we = ram_we;
        if (reqcnt == gdly) begin
          ram_gnt = 1'b1;
          gcyc = c;
        end
        reqcnt++;
      end
      if (gcyc >= 0 && c == gcyc + 2) ram_rvalid = 1'b1;
      if (mem_ready) begin
        o_rdy++;
        o_rdycyc = c;
        o_data = mem_data_read;
        o_mis = mem_misalign;
        rdy_seen = c;
      end
      if (rdy_seen >= 0 && c >= rdy_seen + hold + 1) mem_valid = 1'b0;
    end
    mem_valid = 1'b0;
    ram_gnt = 1'b0;
    ram_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_size = '0;
    mem_data_write = '0; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    tick();
    tick();
    chk("rst_ready",  64'(mem_ready), 64'd0);
    chk("rst_mis",    64'(mem_misalign), 64'd0);
    chk("rst_data",   mem_data_read, 64'd0);
    chk("rst_req",    64'(ram_req), 64'd0);
    chk("rst_we",     64'(ram_we), 64'd0);
    chk("rst_addr",   64'(ram_addr), 64'd0);
    chk("rst_wdata",  ram_wdata, 64'd0);
    chk("rst_wstrb",  64'(ram_wstrb), 64'd0);
    rst = 1'b1;
    tick();

    // ld, aligned, grant immediately
    xact(1'b0, 32'h8000_1008, 3'd3, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 1'b0);
    chk("ld_raddr", 64'(o_raddr), 64'h8000_1008);
    chk("ld_strb",  64'(o_strb), 64'h00);
    chk("ld_we",    64'(o_we), 64'd0);
    chk("ld_reqs",  64'(o_reqs), 64'd1);
    chk("ld_nrdy",  64'(o_rdy), 64'd1);
    chk("ld_lat",   64'(o_rdycyc), 64'd4);
    chk("ld_mis",   64'(o_mis), 64'd0);
    chk("ld_data",  o_data, 64'h1122_3344_5566_7788);
    chk("ld_hold",  mem_data_read, 64'h1122_3344_5566_7788);

    xact(1'b0, 32'h8000_0003, 3'd0, 64'd0, 64'h0000_0000_8500_0000, 0, 0, 1'b0);
    chk("lb_data",  o_data, 64'hFFFF_FFFF_FFFF_FF85);
    chk("lb_raddr", 64'(o_raddr), 64'h8000_0000);
    xact(1'b0, 32'h8000_0003, 3'd4, 64'd0, 64'h0000_0000_8500_0000, 0, 0, 1'b0);
    chk("lbu_data", o_data, 64'h0000_0000_0000_0085);

    xact(1'b0, 32'h8000_0002, 3'd1, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lh_data",  o_data, 64'hFFFF_FFFF_FFFF_B4A5);
    xact(1'b0, 32'h8000_0002, 3'd5, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lhu_data", o_data, 64'h0000_0000_0000_B4A5);
    xact(1'b0, 32'h8000_0004, 3'd2, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lw_data",  o_data, 64'hFFFF_FFFF_F0E1_D2C3);
    xact(1'b0, 32'h8000_0004, 3'd6, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lwu_data", o_data, 64'h0000_0000_F0E1_D2C3);
    xact(1'b0, 32'h8000_0001, 3'd0, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lb1_data", o_data, 64'hFFFF_FFFF_FFFF_FF96);
    chk("lb1_mis",  64'(o_mis), 64'd0);
    xact(1'b0, 32'h8000_0006, 3'd4, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("lbu6_data", o_data, 64'h0000_0000_0000_00E1);
    xact(1'b0, 32'h8000_0000, 3'd2, 64'd0, 64'h0000_0000_7FFF_FFFF, 0, 0, 1'b0);
    chk("lwpos_data", o_data, 64'h0000_0000_7FFF_FFFF);
    xact(1'b0, 32'h8000_0000, 3'd7, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);
    chk("sz7_data", o_data, 64'd0);

    // stores: data captured as 0 even though the RAM drives rdata
    xact(1'b1, 32'h8000_0006, 3'd1, 64'h0000_0000_0000_ABCD, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1'b0);
    chk("sh_raddr", 64'(o_raddr), 64'h8000_0000);
    chk("sh_strb",  64'(o_strb), 64'hC0);
    chk("sh_wdata", o_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we",    64'(o_we), 64'd1);
    chk("sh_nrdy",  64'(o_rdy), 64'd1);
    chk("sh_lat",   64'(o_rdycyc), 64'd4);
    chk("sh_data",  o_data, 64'd0);
    xact(1'b1, 32'h8000_0004, 3'd2, 64'hFFFF_FFFF_1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1'b0);
    chk("sw_strb",  64'(o_strb), 64'hF0);
    chk("sw_wdata", o_wdata, 64'h1122_3344_0000_0000);
    xact(1'b1, 32'h8000_0005, 3'd0, 64'h0000_0000_0000_005A, 64'd0, 0, 0, 1'b0);
    chk("sb_strb",  64'(o_strb), 64'h20);
    chk("sb_wdata", o_wdata, 64'h0000_5A00_0000_0000);
    xact(1'b1, 32'h8000_0010, 3'd3, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 1'b0);
    chk("sd_raddr", 64'(o_raddr), 64'h8000_0010);
    chk("sd_strb",  64'(o_strb), 64'hFF);
    chk("sd_wdata", o_wdata, 64'h0123_4567_89AB_CDEF);

    // misaligned accesses: no RAM traffic, ready in cycle 1, data forced to 0
    xact(1'b0, 32'h8000_0000, 3'd3, 64'd0, 64'h5555_5555_5555_5555, 0, 0, 1'b0);
    chk("pre_mis_data", o_data, 64'h5555_5555_5555_5555);
    xact(1'b0, 32'h8000_0002, 3'd2, 64'd0, 64'h5555_5555_5555_5555, 0, 0, 1'b0);
    chk("lw_mis_reqs", 64'(o_reqs), 64'd0);
    chk("lw_mis_lat",  64'(o_rdycyc), 64'd1);
    chk("lw_mis_flag", 64'(o_mis), 64'd1);
    chk("lw_mis_data", o_data, 64'd0);
    chk("lw_mis_nrdy", 64'(o_rdy), 64'd1);
    xact(1'b1, 32'h8000_0001, 3'd1, 64'h1234, 64'd0, 0, 0, 1'b0);
    chk("sh_mis_reqs", 64'(o_reqs), 64'd0);
    chk("sh_mis_flag", 64'(o_mis), 64'd1);
    xact(1'b0, 32'h8000_0004, 3'd3, 64'd0, 64'd0, 0, 0, 1'b0);
    chk("ld_mis_flag", 64'(o_mis), 64'd1);

    // stalled grant with mem_valid lingering after the handshake
    xact(1'b0, 32'h8000_0008, 3'd3, 64'd0, 64'hCAFE_F00D_0BAD_BEEF, 5, 3, 1'b0);
    chk("stall_reqs", 64'(o_reqs), 64'd1);
    chk("stall_nrdy", 64'(o_rdy), 64'd1);
    chk("stall_lat",  64'(o_rdycyc), 64'd9);
    chk("stall_data", o_data, 64'hCAFE_F00D_0BAD_BEEF);
    xact(1'b0, 32'h8000_0000, 3'd2, 64'd0, 64'h0000_0000_1234_5678, 0, 0, 1'b0);
    chk("after_stall_lat",  64'(o_rdycyc), 64'd4);
    chk("after_stall_data", o_data, 64'h0000_0000_1234_5678);

    // mem_valid dropped during the transaction: still completes once
    xact(1'b0, 32'h8000_0000, 3'd4, 64'd0, 64'h0000_0000_0000_0042, 0, 0, 1'b1);
    chk("early_nrdy", 64'(o_rdy), 64'd1);
    chk("early_data", o_data, 64'h42);

    // asynchronous reset while waiting for rvalid
    mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 32'h8000_0020; mem_size = 3'd3;
    ram_rdata = 64'h7777_7777_7777_7777;
    tick();
    chk("rw_req", 64'(ram_req), 64'd1);
    ram_gnt = 1'b1;
    tick();
    ram_gnt = 1'b0;
    chk("rw_wait_req", 64'(ram_req), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rw_data", mem_data_read, 64'd0);
    chk("rw_req0", 64'(ram_req), 64'd0);
    chk("rw_rdy0", 64'(mem_ready), 64'd0);
    mem_valid = 1'b0;
    tick();
    rst = 1'b1;
    ram_rvalid = 1'b1;
    tick();
    ram_rvalid = 1'b0;
    chk("rw_stray_rdy", 64'(mem_ready), 64'd0);
    tick();
    chk("rw_stray_rdy2", 64'(mem_ready), 64'd0);
    chk("rw_stray_req",  64'(ram_req), 64'd0);
    xact(1'b0, 32'h8000_0018, 3'd3, 64'd0, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0, 1'b0);
    chk("post_rst_lat",  64'(o_rdycyc), 64'd4);
    chk("post_rst_data", o_data, 64'h0F0F_0F0F_F0F0_F0F0);
    chk("post_rst_raddr", 64'(o_raddr), 64'h8000_0018);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
